// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// The default configuration is WIDTH=32, DEPTH=32, NREAD=2, NWRITE=2.
// The clear sequencer state encoding is also defined here.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NREAD  = 2;
  localparam int unsigned DEF_NWRITE = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clear_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer for regfile_mp.
// A ClearReq seen while idle starts a sweep that zeroes registers
// 1..DEPTH-1, one register per clock. Register 0 is skipped because
// it is hardwired to zero. ClearReq is ignored while a sweep runs.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          ClearReq,
  output logic          ClearBusy,
  output logic [AW-1:0] sweep_addr,
  output logic          sweep_we
);

  clear_state_e  state_q, state_d;
  logic [AW-1:0] counter_q, counter_d;

  // State and sweep-counter registers; reset aborts any sweep in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!Reset_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Next-state logic: start at register 1, stop after register DEPTH-1.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d   = state_q;
    counter_d = counter_q;
    unique case (state_q)
      IDLE: begin
        if (ClearReq) begin
          state_d   = SWEEP;
          counter_d = AW'(1);
        end
      end
      SWEEP: begin
        if (counter_q == AW'(DEPTH - 1)) begin
          state_d   = IDLE;
          counter_d = '0;
        end else begin
          counter_d = counter_q + AW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
  end

  assign ClearBusy  = (state_q == SWEEP);
  assign sweep_we   = (state_q == SWEEP);
  assign sweep_addr = counter_q;

endmodule : regfile_clear_fsm

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, a hardwired-zero
// register 0, and a sequenced clear operation.
// Optional macro REGFILE_MP_BYPASS_EN: when it is defined, a read forwards
// same-cycle accepted write data. Port 1 has priority.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  parameter  int unsigned NREAD  = DEF_NREAD,
  parameter  int unsigned NWRITE = DEF_NWRITE,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NREAD*AW-1:0]     ReadRegister,
  output logic [NREAD*WIDTH-1:0]  ReadData,
  input  logic [NWRITE*AW-1:0]    WriteRegister,
  input  logic [NWRITE*WIDTH-1:0] WriteData,
  input  logic [NWRITE-1:0]       RegWrite,
  input  logic                    ClearReq,
  output logic                    ClearBusy
);

  // Reject unsupported configurations at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("regfile_mp: WIDTH must be at least 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be a power of two >= 4");
  end
  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("regfile_mp: NREAD must be in 1..4");
  end
  if (NWRITE < 1 || NWRITE > 2) begin : g_bad_nwrite
    $error("regfile_mp: NWRITE must be in 1..2");
  end

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [NWRITE-1:0] wr_accept;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     sweep_addr;
  logic              sweep_we;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ClearReq   (ClearReq),
    .ClearBusy  (ClearBusy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  // A write port is accepted when enabled, not clearing, and not targeting r0.
  always_comb begin
    wr_accept = '0;
    for (int p = 0; p < NWRITE; p++) begin
      wr_accept[p] = RegWrite[p] && !ClearBusy &&
                     (WriteRegister[p*AW +: AW] != '0);
    end
  end

  // Next register contents: the sweep owns the array while busy; otherwise
  // accepted writes land in ascending port order, so port 1 wins a tie.
  always_comb begin
    regs_d = regs_q;
    if (sweep_we) begin
      regs_d[sweep_addr] = '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_accept[p]) begin
          regs_d[WriteRegister[p*AW +: AW]] = WriteData[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Register array; reset zeroes every entry asynchronously.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: the array is reset because reset must leave every register reading zero.
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports; r0 is forced to zero and never bypassed.
  always_comb begin
    ReadData = '0;
    rd_addr  = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_addr = ReadRegister[k*AW +: AW];
      ReadData[k*WIDTH +: WIDTH] = (rd_addr == '0) ? '0 : regs_q[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_accept[p] && (WriteRegister[p*AW +: AW] == rd_addr)) begin
          ReadData[k*WIDTH +: WIDTH] = WriteData[p*WIDTH +: WIDTH];
        end
      end
`endif
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp in its default configuration.
// It runs directed scenarios followed by randomized traffic. A
// behavioural model of the register file supplies expected values.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          Clk;
  logic          Reset_n;
  logic [2*AW-1:0] ReadRegister;
  logic [2*W-1:0]  ReadData;
  logic [2*AW-1:0] WriteRegister;
  logic [2*W-1:0]  WriteData;
  logic [1:0]      RegWrite;
  logic            ClearReq;
  logic            ClearBusy;

  // Bench-side per-port views of the flattened buses.
  logic [AW-1:0] ra [2];
  logic [AW-1:0] wa [2];
  logic [W-1:0]  wd [2];
  logic [1:0]    we;
  logic          clr;

  assign ReadRegister  = {ra[1], ra[0]};
  assign WriteRegister = {wa[1], wa[0]};
  assign WriteData     = {wd[1], wd[0]};
  assign RegWrite      = we;
  assign ClearReq      = clr;

  regfile_mp dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .ReadRegister  (ReadRegister),
    .ReadData      (ReadData),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ClearReq      (ClearReq),
    .ClearBusy     (ClearBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: register contents, plus the set of registers still
  // waiting to be cleared (sweep runs upward from m_ptr).
  logic [W-1:0] m_mem [D];
  bit           m_busy;
  int           m_ptr;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (!m_busy) begin
      for (int p = 0; p < 2; p++) begin
        if (we[p] && wa[p] == a) v = wd[p];
      end
    end
`endif
    return v;
  endfunction

  task automatic check_reads(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.rd%0d[r%0d]", tag, k, ra[k]), ReadData[k*W +: W], exp_read(ra[k]));
    end
    check({tag, ".busy"}, {31'b0, ClearBusy}, {31'b0, m_busy});
  endtask

  // Advance one clock edge, updating the model with the current inputs.
  task automatic tick();
    logic [W-1:0] nxt [D];
    bit nb;
    int np;
    nxt = m_mem;
    nb  = m_busy;
    np  = m_ptr;
    if (m_busy) begin
      nxt[m_ptr] = '0;
      np = m_ptr + 1;
      if (np == D) begin
        nb = 0;
        np = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (we[p] && wa[p] != 0) nxt[wa[p]] = wd[p];
      end
      if (clr) begin
        nb = 1;
        np = 1;
      end
    end
    @(posedge Clk);
    m_mem  = nxt;
    m_busy = nb;
    m_ptr  = np;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_busy = 0;
    m_ptr  = 0;
  endtask

  task automatic idle_inputs();
    we  = 2'b00;
    clr = 1'b0;
    wa[0] = '0; wa[1] = '0;
    wd[0] = '0; wd[1] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < D; i += 2) begin
      ra[0] = AW'(i);
      ra[1] = AW'(i + 1);
      #1;
      check($sformatf("%s[r%0d]", tag, i), ReadData[0 +: W], '0);
      check($sformatf("%s[r%0d]", tag, i + 1), ReadData[W +: W], '0);
    end
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    model_reset();
    idle_inputs();
    ra[0] = '0; ra[1] = '0;
    Reset_n = 1'b0;

    // Reset state: every register zero and the file not clearing.
    #2;
    check("reset.busy", {31'b0, ClearBusy}, '0);
    check_all_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Write 42 to r2 on the first edge after reset; both ports read it.
    we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'd42;
    tick();
    idle_inputs();
    ra[0] = 5'd2; ra[1] = 5'd2;
    #1;
    check("wr42.p0", ReadData[0 +: W], 32'd42);
    check("wr42.p1", ReadData[W +: W], 32'd42);
    ra[1] = 5'd3;
    #1;
    check("r3_zero", ReadData[W +: W], 32'd0);

    // A disabled write is ignored, and a write to r0 is discarded.
    wa[0] = 5'd2; wd[0] = 32'd99; we = 2'b00;
    tick();
    ra[0] = 5'd2;
    #1;
    check("noen.r2", ReadData[0 +: W], 32'd42);
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'd42;
    tick();
    idle_inputs();
    ra[0] = 5'd0;
    #1;
    check("r0.zero", ReadData[0 +: W], 32'd0);

    // Dual writes to different addresses, then a same-address collision.
    we = 2'b11; wa[0] = 5'd5; wd[0] = 32'd427; wa[1] = 5'd6; wd[1] = 32'd563;
    tick();
    wa[0] = 5'd7; wd[0] = 32'h11; wa[1] = 5'd7; wd[1] = 32'h22;
    tick();
    idle_inputs();
    ra[0] = 5'd5; ra[1] = 5'd6;
    #1;
    check("dual.r5", ReadData[0 +: W], 32'd427);
    check("dual.r6", ReadData[W +: W], 32'd563);
    ra[0] = 5'd7;
    #1;
    check("collide.r7", ReadData[0 +: W], 32'h22);

    // Same-cycle read of a register being written (with or without bypass).
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hDEAD;
    ra[0] = 5'd9; ra[1] = 5'd9;
    #1;
    check_reads("byp.pre");
    tick();
    idle_inputs();
    #1;
    check("byp.post", ReadData[0 +: W], 32'hDEAD);

    // Fill r1..r31 with index*3, then clear. A mid-sweep write to r4 is dropped.
    for (int i = 1; i < D; i += 2) begin
      we = 2'b11;
      wa[0] = AW'(i);     wd[0] = 32'(i * 3);
      wa[1] = AW'(i + 1); wd[1] = 32'((i + 1) * 3);
      if (i + 1 >= D) we[1] = 1'b0;
      tick();
    end
    idle_inputs();
    ra[0] = 5'd31; ra[1] = 5'd17;
    #1;
    check("fill.r31", ReadData[0 +: W], 32'd93);
    check("fill.r17", ReadData[W +: W], 32'd51);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (ClearBusy && n < 100) begin
      if (n == 10) begin
        we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'd7;
        clr = 1'b1;
      end else begin
        idle_inputs();
      end
      ra[0] = AW'($urandom_range(0, D - 1));
      ra[1] = 5'd4;
      #1;
      check_reads("sweep");
      tick();
      n++;
    end
    idle_inputs();
    check("sweep.cycles", 32'(n), 32'd31);
    check("sweep.done", {31'b0, ClearBusy}, '0);
    check_all_zero("cleared");

    // Reset in the middle of a sweep aborts the sweep and leaves the file zeroed.
    for (int i = 1; i < 8; i++) begin
      we[0] = 1'b1; wa[0] = AW'(i); wd[0] = 32'(100 + i);
      tick();
    end
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    check("midrst.busy_before", {31'b0, ClearBusy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst.busy", {31'b0, ClearBusy}, '0);
    check_all_zero("midrst");
    @(negedge Clk);
    Reset_n = 1'b1;
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h55;
    tick();
    idle_inputs();
    ra[0] = 5'd3;
    #1;
    check("postrst.wr", ReadData[0 +: W], 32'h55);

    // Randomized traffic against the model, including occasional clears.
    for (int i = 0; i < 400; i++) begin
      ra[0] = AW'($urandom_range(0, D - 1));
      ra[1] = AW'($urandom_range(0, D - 1));
      we    = 2'($urandom_range(0, 3));
      wa[0] = AW'($urandom_range(0, D - 1));
      wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : AW'($urandom_range(0, D - 1));
      if ($urandom_range(0, 3) == 0) ra[0] = wa[0];
      wd[0] = $urandom;
      wd[1] = $urandom;
      clr   = ($urandom_range(0, 59) == 0);
      #1;
      check_reads("rand");
      tick();
    end
    idle_inputs();
    #1;
    check_reads("rand.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32: data bits per register.
REQ-002 Parameter DEPTH, default 32: number of registers, power of two >= 4; AW = log2(DEPTH).
REQ-003 Parameter NREAD, default 2: number of read ports, 1..4.
REQ-004 Parameter NWRITE, default 2: number of write ports, 1..2.
REQ-005 Clk  input  1  single clock, positive-edge triggered.
REQ-006 Reset_n  input  1  asynchronous active-low reset.
REQ-007 ReadRegister  input  NREAD*AW  read addresses; port k uses slice [k*AW +: AW].
REQ-008 ReadData  output  NREAD*WIDTH  read data; port k uses slice [k*WIDTH +: WIDTH].
REQ-009 WriteRegister  input  NWRITE*AW  write addresses, sliced per port.
REQ-010 WriteData  input  NWRITE*WIDTH  write data, sliced per port.
REQ-011 RegWrite  input  NWRITE  per-port write enable, active high.
REQ-012 ClearReq  input  1  single-cycle request to zero the whole file.
REQ-013 ClearBusy  output  1  high while the clear sweep runs.

Function
REQ-014 Reads SHALL be combinational: ReadData slice k reflects the register addressed by slice k in the same cycle.
REQ-015 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-016 Writes SHALL commit on the rising Clk edge when the port's RegWrite is high; new data is visible on reads immediately after that edge.
REQ-017 RegWrite low on a port SHALL leave every register unchanged for that port.
REQ-018 Two write ports enabled to the same nonzero address in one cycle: port 1 data SHALL win.
REQ-019 Writes on different addresses in one cycle SHALL both commit.
REQ-020 A write SHALL modify only the addressed register; all others hold.
REQ-021 Clear FSM states: IDLE, SWEEP.
REQ-022 IDLE -> SWEEP on a ClearReq-high edge; counter loads 1; ClearBusy rises the next cycle.
REQ-023 In SWEEP, each edge SHALL zero register[counter] and increment the counter; after register DEPTH-1 is zeroed, the FSM SHALL return to IDLE. The sweep lasts DEPTH-1 cycles.
REQ-024 While ClearBusy is high, all RegWrite inputs SHALL be ignored; reads remain live and show partially cleared contents.
REQ-025 A ClearReq during SWEEP SHALL be ignored; the sweep is not restarted.
REQ-026 A write in the same cycle as an accepted ClearReq (FSM in IDLE) SHALL commit; the sweep then zeroes it.
REQ-027 Out-of-range parameters SHALL be rejected at elaboration.

Reset
REQ-028 On Reset_n low, asynchronously: all registers 0, FSM IDLE, counter 0, ClearBusy 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; all registers are zeroed anyway.
REQ-030 After reset deassertion, the first write SHALL be accepted on the first rising edge.

Configuration
REQ-031 Macro REGFILE_MP_BYPASS_EN defined: a read whose address matches an enabled, accepted write in the same cycle SHALL return that write's WriteData combinationally, with port 1 priority. Address 0 is never bypassed, and there is no bypass while ClearBusy is high.
REQ-032 Macro REGFILE_MP_BYPASS_EN undefined: reads SHALL return the pre-edge stored value until the write commits.

Structure
REQ-033 Package regfile_pkg SHALL hold the default WIDTH/DEPTH/NREAD/NWRITE constants and the IDLE/SWEEP state encoding.
REQ-034 The clear sequencer SHALL be the sub-module regfile_clear_fsm: inputs Clk, Reset_n, ClearReq; outputs ClearBusy, the sweep address and the sweep write strobe.

Verification
REQ-035 Reset, then write 42 to r2 on port 0; read r2 on both read ports -> 42, 42; r3 -> 0.
REQ-036 RegWrite=0 with WriteData=99 to r2 -> r2 stays 42. Write 42 to r0 -> r0 reads 0.
REQ-037 Same edge: port 0 writes r5=427 and port 1 writes r6=563, then both ports write r7 (0x11 and 0x22) -> r5=427, r6=563, r7=0x22.
REQ-038 Fill r1..r31 with index*3, then pulse ClearReq -> ClearBusy high for 31 cycles; a write of r4=7 mid-sweep is dropped; afterwards all registers read 0.
REQ-039 With REGFILE_MP_BYPASS_EN: write r9=0xDEAD while reading r9 -> 0xDEAD before the edge. Without it -> old value before the edge, 0xDEAD after.
REQ-040 Assert Reset_n low midway through a sweep -> ClearBusy falls immediately, all registers read 0, and a write on the next edge commits.
